// File: rtl/wave_judge_seq.sv
// Frame waveform judge: sequences three divider quotients, picks the strict maximum, debounces over CONFIRM frames.
// wave/wave_valid appear 3 cycles after the last div_done; acc_done while busy is dropped and flagged as overrun.
module wave_judge_seq #(
  parameter int Q_W     = 28,
  parameter int CONFIRM = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  acc_done,
  output logic                  div_start,
  output logic [1:0]            div_sel,
  input  logic                  div_done,
  input  logic signed [Q_W-1:0] div_quot,
  output logic [1:0]            wave,
  output logic                  wave_valid,
  output logic                  busy,
  output logic                  overrun,
  output logic                  timeout_err,
  input  logic                  clr_err
);

  localparam int CNT_W = $clog2(CONFIRM + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COMPARE, FILTER} state_t;

  state_t                state, state_nxt;
  logic [1:0]            ch;
  logic [1:0]            cls, cls_nxt;
  logic [1:0]            cand;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [TMR_W-1:0]      timer;
  logic signed [Q_W-1:0] r0, r1, r2;
  logic                  tmo_hit;

  // div_done on the last allowed cycle still counts as a result, not a timeout
  assign tmo_hit = (state == WAIT) && !div_done && (timer == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc_done && en) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (div_done)     state_nxt = (ch == 2'd2) ? COMPARE : ISSUE;
        else if (tmo_hit) state_nxt = IDLE;
      end
      COMPARE: state_nxt = FILTER;
      FILTER:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    div_start = (state == ISSUE);
    div_sel   = ((state == ISSUE) || (state == WAIT)) ? ch : 2'd0;
    busy      = (state != IDLE);
  end

  always_comb begin
    cls_nxt = 2'd3;
    if      ((r0 > r1) && (r0 > r2)) cls_nxt = 2'd0;
    else if ((r1 > r0) && (r1 > r2)) cls_nxt = 2'd1;
    else if ((r2 > r0) && (r2 > r1)) cls_nxt = 2'd2;

    if (cls == cand) cnt_nxt = (cnt == CNT_W'(CONFIRM)) ? cnt : cnt + CNT_W'(1);
    else             cnt_nxt = CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch          <= 2'd0;
      timer       <= '0;
      r0          <= '0;
      r1          <= '0;
      r2          <= '0;
      cls         <= 2'd3;
      cand        <= 2'd3;
      cnt         <= '0;
      wave        <= 2'd3;
      wave_valid  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      wave_valid <= 1'b0;
      case (state)
        IDLE:  if (acc_done && en) ch <= 2'd0;
        ISSUE: timer <= '0;
        WAIT: begin
          if (div_done) begin
            case (ch)
              2'd0:    r0 <= div_quot;
              2'd1:    r1 <= div_quot;
              default: r2 <= div_quot;
            endcase
            if (ch != 2'd2) ch <= ch + 2'd1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        COMPARE: cls <= cls_nxt;
        FILTER: begin
          cand <= cls;
          cnt  <= cnt_nxt;
          if ((cnt_nxt == CNT_W'(CONFIRM)) && (cls != wave)) begin
            wave       <= cls;
            wave_valid <= 1'b1;
          end
        end
        default: ;
      endcase

      // a set event in the same cycle as clr_err takes priority
      if (acc_done && (state != IDLE)) overrun <= 1'b1;
      else if (clr_err)                overrun <= 1'b0;

      if (tmo_hit)      timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wave_judge_seq.sv
// Randomised frame bench for wave_judge_seq with a history-based reference model and a per-cycle compare process.
module tb_wave_judge_seq;

  localparam int Q_W     = 28;
  localparam int CONFIRM = 3;
  localparam int TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  rst, en, acc_done, div_done, clr_err;
  logic signed [Q_W-1:0] div_quot;
  logic                  div_start, wave_valid, busy, overrun, timeout_err;
  logic [1:0]            div_sel, wave;

  wave_judge_seq #(.Q_W(Q_W), .CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en(en), .acc_done(acc_done),
    .div_start(div_start), .div_sel(div_sel), .div_done(div_done), .div_quot(div_quot),
    .wave(wave), .wave_valid(wave_valid), .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;

  // model: classes of completed frames, and the pulses they must produce
  int hist[$];
  int m_wave = 3;
  int pend_cyc[$];
  int pend_wave[$];
  int pidx = 0;
  int shown_wave = 3;
  int sel_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_frame(input int q[3]);
    int cls;
    int n;
    bit all;
    cls = 3;
    for (int k = 0; k < 3; k++)
      if (q[k] > q[(k+1)%3] && q[k] > q[(k+2)%3]) cls = k;
    hist.push_back(cls);
    n = hist.size();
    if (n >= CONFIRM) begin
      all = 1'b1;
      for (int i = 0; i < CONFIRM; i++) if (hist[n-1-i] != cls) all = 1'b0;
      if (all && cls != m_wave) begin
        m_wave = cls;
        pend_cyc.push_back(cyc + 3);
        pend_wave.push_back(cls);
      end
    end
  endtask

  always @(negedge clk) begin
    bit exp_wv;
    exp_wv = 1'b0;
    if (!rst) shown_wave = 3;
    else if (pidx < pend_cyc.size() && pend_cyc[pidx] == cyc) begin
      shown_wave = pend_wave[pidx];
      exp_wv = 1'b1;
      pidx++;
    end
    chk("wave", wave, shown_wave);
    chk("wave_valid", wave_valid, exp_wv);
    if (wave_valid === 1'b1) pulses++;
    if (div_start === 1'b1) begin
      sel_log.push_back(div_sel);
      chk("start_busy", busy, 1);
    end
  end

  task automatic run_frame(input int q0, input int q1, input int q2, input bit ovr, input int hold_ch);
    int q[3];
    int d;
    int base;
    int exp_n;
    bit got;
    q[0] = q0; q[1] = q1; q[2] = q2;
    base  = sel_log.size();
    exp_n = (hold_ch < 0) ? 3 : hold_ch + 1;
    en = 1'b1; acc_done = 1'b1; div_done = 1'b0;
    step();
    acc_done = 1'b0;
    en = 1'($urandom_range(0, 1));
    for (int c = 0; c < 3; c++) begin
      got = 1'b0;
      for (int t = 0; t < 8; t++) begin
        if (div_start === 1'b1) begin got = 1'b1; break; end
        step();
      end
      chk("div_start_seen", got, 1);
      if (!got) return;
      chk("div_sel_issue", div_sel, c);
      if (c == hold_ch) begin
        repeat (TIMEOUT) step();
        chk("tmo_busy_before", busy, 1);
        chk("tmo_err_before", timeout_err, 0);
        step();
        chk("tmo_err", timeout_err, 1);
        chk("tmo_busy_after", busy, 0);
        break;
      end
      step();
      if (ovr && c == 1) begin
        acc_done = 1'b1; clr_err = 1'b1;
        step();
        acc_done = 1'b0; clr_err = 1'b0;
        chk("overrun_set", overrun, 1);
      end
      d = $urandom_range(0, 4);
      repeat (d) step();
      chk("div_sel_wait", div_sel, c);
      div_done = 1'b1;
      div_quot = Q_W'(q[c]);
      if (c == 2) model_frame(q);
      step();
      div_done = 1'b0;
      div_quot = Q_W'($urandom);
    end
    if (hold_ch < 0) begin
      step(); step();
      chk("busy_end", busy, 0);
      step();
    end
    chk("sel_count", sel_log.size() - base, exp_n);
    for (int i = 0; i < exp_n && base + i < sel_log.size(); i++) chk("sel_seq", sel_log[base+i], i);
  endtask

  task automatic idle_noise();
    int n;
    n = $urandom_range(0, 3);
    repeat (n) begin
      div_done = 1'($urandom_range(0, 1));
      div_quot = Q_W'($urandom);
      if ($urandom_range(0, 3) == 0) begin acc_done = 1'b1; en = 1'b0; end
      step();
      if (acc_done) begin
        acc_done = 1'b0;
        chk("en0_ignored", busy, 0);
      end
      div_done = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wave"}, wave, 3);
    chk({tag, "_wave_valid"}, wave_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_div_start"}, div_start, 0);
    chk({tag, "_div_sel"}, div_sel, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    int rq[3];
    rst = 1'b0; en = 1'b0; acc_done = 1'b0; div_done = 1'b0; div_quot = '0; clr_err = 1'b0;
    repeat (3) step();
    chk_reset_vals("rst");
    rst = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);

    // three identical sine frames: only the third confirms
    for (int i = 0; i < 3; i++) begin
      run_frame(900, 100, -50, 1'b0, -1);
      if (i < 2) begin
        chk("sin_wave_pending", wave, 3);
        chk("sin_no_pulse", pulses, 0);
      end
    end
    chk("sin_wave", wave, 0);
    chk("sin_pulses", pulses, 1);

    // tie between sin and square resolves to unknown
    for (int i = 0; i < 3; i++) begin
      run_frame(500, 500, 10, 1'b0, -1);
      if (i < 2) chk("tie_wave_pending", wave, 0);
    end
    chk("tie_wave", wave, 3);

    // decisions 1,1,2,1,1,1: the interloper restarts the run
    run_frame(10, 900, 5, 1'b0, -1);
    run_frame(10, 900, 5, 1'b0, -1);
    run_frame(-5, -3, -1, 1'b0, -1);
    run_frame(10, 900, 5, 1'b0, -1);
    run_frame(10, 900, 5, 1'b0, -1);
    chk("seq_wave_5th", wave, 3);
    run_frame(10, 900, 5, 1'b0, -1);
    chk("seq_wave_6th", wave, 1);

    // a timed-out frame leaves the confirmation run intact
    run_frame(900, 100, -50, 1'b0, -1);
    run_frame(900, 100, -50, 1'b0, -1);
    chk("tmo_pre_wave", wave, 1);
    run_frame(900, 100, -50, 1'b0, 1);
    step();
    chk("tmo_err_sticky", timeout_err, 1);
    run_frame(900, 100, -50, 1'b0, -1);
    chk("tmo_post_wave", wave, 0);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("tmo_err_cleared", timeout_err, 0);

    // acc_done mid-frame raises overrun but the frame completes normally
    chk("ovr_pre", overrun, 0);
    run_frame(10, 900, 5, 1'b1, -1);
    chk("ovr_sticky", overrun, 1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("ovr_cleared", overrun, 0);

    // reset while waiting on channel 1
    en = 1'b1; acc_done = 1'b1; step(); acc_done = 1'b0;
    step();
    div_done = 1'b1; div_quot = Q_W'(77); step(); div_done = 1'b0;
    chk("mid_issue_sel", div_sel, 1);
    step(); step();
    chk("mid_wait_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    hist.delete();
    m_wave = 3;
    step();
    rst = 1'b1;
    step();
    chk_reset_vals("after_rst");
    step();
    chk("after_rst_idle", busy, 0);
    run_frame(900, 100, -50, 1'b0, -1);

    // random frames; repeated triples make confirmations likely
    rq[0] = 0; rq[1] = 0; rq[2] = 0;
    for (int n = 0; n < 30; n++) begin
      idle_noise();
      if ($urandom_range(0, 3) == 0 || n == 0)
        for (int k = 0; k < 3; k++) rq[k] = int'($urandom_range(0, 8)) * 100 - 400;
      run_frame(rq[0], rq[1], rq[2], 1'b0, -1);
    end
    repeat (4) step();
    chk("pulses_drained", pidx, pend_cyc.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got %0d want %0d cycles", cyc, 40000);
    $fatal(1);
  end

endmodule
